// File: rtl/ariane_pkg.sv
// ariane_pkg: HPM event register layout, bit positions and CSR word selects.
package ariane_pkg;
  localparam int unsigned HPM_SEL_W    = 8;
  localparam int unsigned HPM_OFEN_BIT = 30;
  localparam int unsigned HPM_OF_BIT   = 31;
  localparam logic [HPM_SEL_W-1:0] HPM_EVT_NONE = '0;

  typedef enum logic [1:0] {
    HPM_CNT_LO  = 2'd0,
    HPM_CNT_HI  = 2'd1,
    HPM_EVT_REG = 2'd2,
    HPM_INHIBIT = 2'd3
  } hpm_sel_e;

  typedef struct packed {
    logic                 of;
    logic                 ofen;
    logic [HPM_SEL_W-1:0] select;
  } hpm_event_t;
endpackage

// File: rtl/riscv.sv
// riscv: ISA-wide width constants shared by the CSR-side blocks.
package riscv;
  localparam int unsigned XLEN = 32;
endpackage

// File: rtl/hpm_counters_if.sv
// hpm_counters_if: CSR access port of the performance counter bank.
interface hpm_counters_if;
  logic [4:0]             addr_i;
  logic [1:0]             sel_i;
  logic                   we_i;
  logic [riscv::XLEN-1:0] data_i;
  logic [riscv::XLEN-1:0] data_o;

  modport master (output addr_i, sel_i, we_i, data_i, input data_o);
  modport slave  (input addr_i, sel_i, we_i, data_i, output data_o);
endinterface

// File: rtl/hpm_counter.sv
// hpm_counter: one counter slice with event select, overflow flag, write priority.
// Overflow flag/enable exist only when HPM_OVF_IRQ_EN is defined.
module hpm_counter
  import ariane_pkg::*;
#(
  parameter int unsigned CntWidth = 64,
  parameter int unsigned NrEvents = 16,
  parameter int unsigned IncWidth = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clr_i,
  input  logic                               i_freeze,
  input  logic                               i_we_lo,
  input  logic                               i_we_hi,
  input  logic                               i_we_evt,
  input  logic [riscv::XLEN-1:0]             i_wdata,
  input  logic [NrEvents-1:0][IncWidth-1:0]  i_events,
  output logic [CntWidth-1:0]                o_cnt,
  output hpm_event_t                         o_evt
);
  localparam int unsigned XL = riscv::XLEN;

  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] w_cnt_d;
  logic [CntWidth-1:0] w_nxt;
  logic [IncWidth-1:0] w_inc;
  logic                w_carry;
  hpm_event_t          r_evt;
  hpm_event_t          w_evt_d;

  always_comb begin
    w_inc = '0;
    for (int k = 0; k < NrEvents; k++)
      if (!i_freeze && r_evt.select != HPM_EVT_NONE
          && r_evt.select == 8'(k + 1))
        w_inc = i_events[k];
  end

`ifdef HPM_OVF_IRQ_EN
  assign {w_carry, w_nxt} = {1'b0, r_cnt} + (CntWidth + 1)'(w_inc);
`else
  assign w_nxt   = r_cnt + CntWidth'(w_inc);
  assign w_carry = 1'b0;
`endif

  // A software write replaces only its own word and drops the increment.
  always_comb begin
    w_cnt_d = w_nxt;
    if (i_we_lo) begin
      w_cnt_d         = r_cnt;
      w_cnt_d[XL-1:0] = i_wdata;
    end
    if (i_we_hi) begin
      w_cnt_d = r_cnt;
      for (int b = XL; b < CntWidth; b++)
        w_cnt_d[b] = i_wdata[b-XL];
    end
  end

  always_comb begin
    w_evt_d = r_evt;
    if (i_we_evt) begin
      w_evt_d.select = i_wdata[HPM_SEL_W-1:0];
`ifdef HPM_OVF_IRQ_EN
      w_evt_d.ofen = i_wdata[HPM_OFEN_BIT];
      w_evt_d.of   = i_wdata[HPM_OF_BIT];
`endif
    end
    if (w_carry && !(i_we_lo || i_we_hi))
      w_evt_d.of = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_evt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
      r_evt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
      r_evt <= w_evt_d;
    end
  end

  assign o_cnt = r_cnt;
  assign o_evt = r_evt;
endmodule

// File: rtl/hpm_counters.sv
// hpm_counters: bank of programmable hardware performance counters.
// Define HPM_OVF_IRQ_EN to enable overflow flags and ovf_irq_o.
module hpm_counters
  import ariane_pkg::*;
#(
  parameter int unsigned NrCounters = 6,
  parameter int unsigned CntWidth   = 64,
  parameter int unsigned NrEvents   = 16,
  parameter int unsigned IncWidth   = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clr_i,
  input  logic                              debug_mode_i,
  hpm_counters_if.slave                     bus,
  input  logic [NrEvents-1:0][IncWidth-1:0] events_i,
  output logic                              ovf_irq_o
);
  localparam int unsigned XL = riscv::XLEN;

  hpm_sel_e              w_sel;
  logic                  w_hit;
  logic                  w_wr;
  logic [NrCounters-1:0] r_inhibit;
  logic [CntWidth-1:0]   w_cnt [NrCounters];
  hpm_event_t            w_evt [NrCounters];
  logic [XL-1:0]         w_rdata;

  assign w_sel = hpm_sel_e'(bus.sel_i);
  assign w_hit = bus.addr_i < 5'(NrCounters);
  assign w_wr  = bus.we_i && w_hit;

  for (genvar g = 0; g < NrCounters; g++) begin : g_cnt
    logic w_me;
    assign w_me = w_wr && bus.addr_i == 5'(g);
    hpm_counter #(
      .CntWidth (CntWidth),
      .NrEvents (NrEvents),
      .IncWidth (IncWidth)
    ) u_cnt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (clr_i),
      .i_freeze (debug_mode_i || r_inhibit[g]),
      .i_we_lo  (w_me && w_sel == HPM_CNT_LO),
      .i_we_hi  (w_me && w_sel == HPM_CNT_HI),
      .i_we_evt (w_me && w_sel == HPM_EVT_REG),
      .i_wdata  (bus.data_i),
      .i_events (events_i),
      .o_cnt    (w_cnt[g]),
      .o_evt    (w_evt[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_inhibit <= '0;
    else if (clr_i)
      r_inhibit <= '0;
    else if (w_wr && w_sel == HPM_INHIBIT)
      r_inhibit <= bus.data_i[NrCounters-1:0];
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NrCounters; i++)
      if (bus.addr_i == 5'(i)) begin
        unique case (w_sel)
          HPM_CNT_LO: w_rdata = w_cnt[i][XL-1:0];
          HPM_CNT_HI:
            for (int b = XL; b < CntWidth; b++)
              w_rdata[b-XL] = w_cnt[i][b];
          HPM_EVT_REG: begin
            w_rdata[HPM_SEL_W-1:0] = w_evt[i].select;
            w_rdata[HPM_OFEN_BIT]  = w_evt[i].ofen;
            w_rdata[HPM_OF_BIT]    = w_evt[i].of;
          end
          HPM_INHIBIT: w_rdata[NrCounters-1:0] = r_inhibit;
        endcase
      end
  end

  assign bus.data_o = w_rdata;

`ifdef HPM_OVF_IRQ_EN
  logic w_irq;
  logic r_irq;

  always_comb begin
    w_irq = 1'b0;
    for (int i = 0; i < NrCounters; i++)
      w_irq = w_irq | (w_evt[i].of & w_evt[i].ofen);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_irq <= 1'b0;
    else if (clr_i)
      r_irq <= 1'b0;
    else
      r_irq <= w_irq;
  end

  assign ovf_irq_o = r_irq;
`else
  assign ovf_irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_hpm_counters.sv
// tb_hpm_counters: directed scenarios plus randomized traffic against a
// behavioural counter-bank model.
module tb_hpm_counters;
  localparam int NC = 6;
  localparam int NE = 16;
  localparam int IW = 2;
`ifdef HPM_OVF_IRQ_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic clr;
  logic dbg;
  logic [NE-1:0][IW-1:0] ev;
  logic irq;

  hpm_counters_if bus();

  hpm_counters #(
    .NrCounters (NC),
    .CntWidth   (64),
    .NrEvents   (NE),
    .IncWidth   (IW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clr_i        (clr),
    .debug_mode_i (dbg),
    .bus          (bus),
    .events_i     (ev),
    .ovf_irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  logic [63:0]   m_cnt  [NC];
  logic [7:0]    m_sel  [NC];
  logic          m_ofen [NC];
  logic          m_of   [NC];
  logic [NC-1:0] m_inh;
  logic          m_irq;

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = '0; m_sel[i] = '0;
      m_ofen[i] = 1'b0; m_of[i] = 1'b0;
    end
    m_inh = '0;
    m_irq = 1'b0;
  endfunction

  function automatic logic [31:0] exp_rd(int a, int s);
    logic [31:0] r;
    r = '0;
    if (a < NC) begin
      case (s)
        0: r = m_cnt[a][31:0];
        1: r = m_cnt[a][63:32];
        2: r = {m_of[a], m_ofen[a], 22'd0, m_sel[a]};
        default: r = 32'(m_inh);
      endcase
    end
    return r;
  endfunction

  // Value of the whole bank after one clock, from the current inputs.
  function automatic void model_clock();
    logic irq_n;
    logic [NC-1:0] inh_old;
    int a, s, sl;
    logic [64:0] sum;
    logic wlo, whi, wev;
    if (clr) begin
      model_reset();
      return;
    end
    irq_n = 1'b0;
    inh_old = m_inh;
    a = int'(bus.addr_i);
    s = int'(bus.sel_i);
    for (int i = 0; i < NC; i++)
      irq_n = irq_n | (m_of[i] & m_ofen[i]);
    for (int i = 0; i < NC; i++) begin
      sl = int'(m_sel[i]);
      sum = {1'b0, m_cnt[i]};
      if (!dbg && !inh_old[i] && sl >= 1 && sl <= NE)
        sum = sum + 65'(ev[sl-1]);
      wlo = bus.we_i && a == i && s == 0;
      whi = bus.we_i && a == i && s == 1;
      wev = bus.we_i && a == i && s == 2;
      if (wlo) m_cnt[i][31:0] = bus.data_i;
      else if (whi) m_cnt[i][63:32] = bus.data_i;
      else m_cnt[i] = sum[63:0];
      if (wev) begin
        m_sel[i] = bus.data_i[7:0];
        if (OVF) begin
          m_ofen[i] = bus.data_i[30];
          m_of[i] = bus.data_i[31];
        end
      end
      if (OVF && !wlo && !whi && sum[64]) m_of[i] = 1'b1;
    end
    if (bus.we_i && a < NC && s == 3) m_inh = bus.data_i[NC-1:0];
    m_irq = irq_n;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic wr(input int a, input int s, input logic [31:0] d);
    bus.addr_i = 5'(a);
    bus.sel_i = 2'(s);
    bus.data_i = d;
    bus.we_i = 1'b1;
    tick();
    bus.we_i = 1'b0;
  endtask

  task automatic rd(input int a, input int s, output logic [31:0] d);
    bus.we_i = 1'b0;
    bus.addr_i = 5'(a);
    bus.sel_i = 2'(s);
    #1;
    d = bus.data_o;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0; clr = 1'b0; dbg = 1'b0; ev = '0;
    bus.we_i = 1'b0; bus.addr_i = '0; bus.sel_i = '0; bus.data_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL reset_irq got=%b want=0", irq);
    end
    for (int a = 0; a < 8; a++)
      for (int s = 0; s < 4; s++) begin
        rd(a, s, d);
        checks++;
        if (d !== 32'd0) begin
          failures++;
          $display("FAIL reset_read a=%0d s=%0d got=%h want=0", a, s, d);
        end
      end
  endtask

  task automatic test_count();
    logic [31:0] d;
    @(negedge clk);
    wr(0, 2, 32'd3);
    ev[2] = 2'd2;
    repeat (5) tick();
    ev = '0;
    rd(0, 0, d);
    checks++;
    if (d !== 32'd10) begin
      failures++; $display("FAIL count5 got=%h want=0000000a", d);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    wr(2, 0, 32'hFFFF_FFFE);
    wr(2, 1, 32'hFFFF_FFFF);
    wr(2, 2, 32'h4000_0001);
    ev[0] = 2'd3;
    tick();
    ev = '0;
    rd(2, 0, d);
    checks++;
    if (d !== 32'd1) begin
      failures++; $display("FAIL ovf_lo got=%h want=00000001", d);
    end
    rd(2, 1, d);
    checks++;
    if (d !== 32'd0) begin
      failures++; $display("FAIL ovf_hi got=%h want=0", d);
    end
    rd(2, 2, d);
    checks++;
    if (d !== (OVF ? 32'hC000_0001 : 32'h0000_0001)) begin
      failures++; $display("FAIL ovf_evt got=%h ovf_en=%0b", d, OVF);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++; $display("FAIL ovf_irq_early got=%b want=0", irq);
    end
    tick();
    checks++;
    if (irq !== OVF) begin
      failures++; $display("FAIL ovf_irq got=%b want=%b", irq, OVF);
    end
    wr(2, 0, 32'hFFFF_FFFF);
    wr(2, 1, 32'hFFFF_FFFF);
    ev[0] = 2'd1;
    wr(2, 2, 32'h4000_0001);
    ev = '0;
    rd(2, 2, d);
    checks++;
    if (d !== (OVF ? 32'hC000_0001 : 32'h0000_0001)) begin
      failures++; $display("FAIL ovf_hw_wins got=%h ovf_en=%0b", d, OVF);
    end
    rd(2, 0, d);
    checks++;
    if (d !== 32'd0) begin
      failures++; $display("FAIL ovf_wrap got=%h want=0", d);
    end
    wr(2, 2, 32'd0);
  endtask

  task automatic test_write_priority();
    logic [31:0] d;
    wr(3, 2, 32'd1);
    ev[0] = 2'd1;
    repeat (3) tick();
    wr(3, 0, 32'h100);
    ev = '0;
    rd(3, 0, d);
    checks++;
    if (d !== 32'h100) begin
      failures++; $display("FAIL wr_prio got=%h want=00000100", d);
    end
  endtask

  task automatic test_inhibit();
    logic [31:0] d;
    wr(1, 0, 32'h55);
    wr(1, 2, 32'd4);
    wr(1, 3, 32'hFFFF_FFFF);
    rd(1, 3, d);
    checks++;
    if (d !== 32'h3F) begin
      failures++; $display("FAIL inh_read got=%h want=0000003f", d);
    end
    ev[3] = 2'd3;
    repeat (20) tick();
    ev = '0;
    rd(1, 0, d);
    checks++;
    if (d !== 32'h55) begin
      failures++; $display("FAIL inh_freeze got=%h want=00000055", d);
    end
    wr(0, 3, 32'd0);
    dbg = 1'b1;
    ev[3] = 2'd3;
    repeat (20) tick();
    ev = '0;
    dbg = 1'b0;
    rd(1, 0, d);
    checks++;
    if (d !== 32'h55) begin
      failures++; $display("FAIL dbg_freeze got=%h want=00000055", d);
    end
  endtask

  task automatic test_sel_change();
    logic [31:0] d;
    wr(4, 2, 32'd3);
    ev[2] = 2'd1;
    ev[4] = 2'd2;
    repeat (2) tick();
    wr(4, 2, 32'd5);
    repeat (2) tick();
    ev = '0;
    rd(4, 0, d);
    checks++;
    if (d !== 32'd7) begin
      failures++; $display("FAIL sel_change got=%h want=00000007", d);
    end
    rd(4, 2, d);
    checks++;
    if (d !== 32'd5) begin
      failures++; $display("FAIL sel_readback got=%h want=00000005", d);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    wr(7, 0, 32'hDEAD);
    wr(6, 2, 32'd5);
    rd(7, 0, d);
    checks++;
    if (d !== 32'd0) begin
      failures++; $display("FAIL unmapped7 got=%h want=0", d);
    end
    rd(6, 2, d);
    checks++;
    if (d !== 32'd0) begin
      failures++; $display("FAIL unmapped6 got=%h want=0", d);
    end
    wr(5, 2, 32'd200);
    ev = '1;
    repeat (3) tick();
    ev = '0;
    rd(5, 0, d);
    checks++;
    if (d !== 32'd0) begin
      failures++; $display("FAIL sel_oor_hold got=%h want=0", d);
    end
    rd(5, 2, d);
    checks++;
    if (d !== 32'd200) begin
      failures++; $display("FAIL sel_oor_read got=%h want=000000c8", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(0, 2, 32'd3);
    ev[2] = 2'd3;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    rd(0, 0, d);
    checks++;
    if (d !== 32'd0) begin
      failures++; $display("FAIL async_rst got=%h want=0", d);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ev = '0;
    rd(0, 2, d);
    checks++;
    if (d !== 32'd0) begin
      failures++; $display("FAIL async_rst_evt got=%h want=0", d);
    end
    wr(0, 2, 32'd3);
    ev[2] = 2'd1;
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ev = '0;
    rd(0, 0, d);
    checks++;
    if (d !== 32'd0) begin
      failures++; $display("FAIL clr_cnt got=%h want=0", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] wd;
    int ra, rs;
    for (int n = 0; n < 600; n++) begin
      rs = $urandom_range(0, 3);
      wd = $urandom;
      if (rs == 2) wd[7:0] = 8'($urandom_range(0, 20));
      if (rs == 1 && $urandom_range(0, 1) == 0) wd = 32'hFFFF_FFFF;
      bus.addr_i = 5'($urandom_range(0, 7));
      bus.sel_i = 2'(rs);
      bus.data_i = wd;
      bus.we_i = ($urandom_range(0, 2) == 0);
      ev = $urandom;
      dbg = ($urandom_range(0, 9) == 0);
      clr = ($urandom_range(0, 149) == 0);
      tick();
      bus.we_i = 1'b0;
      clr = 1'b0;
      checks++;
      if (irq !== m_irq) begin
        failures++; $display("FAIL rnd_irq n=%0d got=%b want=%b", n, irq, m_irq);
      end
      ra = $urandom_range(0, 7);
      rs = $urandom_range(0, 3);
      rd(ra, rs, d);
      checks++;
      if (d !== exp_rd(ra, rs)) begin
        failures++;
        $display("FAIL rnd_read n=%0d a=%0d s=%0d got=%h want=%h",
                 n, ra, rs, d, exp_rd(ra, rs));
      end
    end
    ev = '0;
    dbg = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_count();
    test_overflow();
    test_write_priority();
    test_inhibit();
    test_sel_change();
    test_unmapped();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
